// File: rtl/lotr_pkg.sv
// lotr_pkg: shared ring types for the tile ring controller.
//   t_opcode   - ring request opcode
//   t_ring_req - one ring request slot {valid, requestor, opcode, address, data}
//   RC_REQ_FIFO_DEPTH - default depth of the local request FIFO
package lotr_pkg;

   typedef enum logic [3:0] {
      OP_NOP    = 4'h0,
      OP_LOAD   = 4'h1,
      OP_STORE  = 4'h2,
      OP_ATOMIC = 4'h3,
      OP_FLUSH  = 4'h4
   } t_opcode;

   typedef struct packed {
      logic        valid;
      logic [9:0]  requestor;
      t_opcode     opcode;
      logic [31:0] address;
      logic [31:0] data;
   } t_ring_req;

   localparam int RC_REQ_FIFO_DEPTH = 4;

endpackage

// File: rtl/rc_req_fifo.sv
// rc_req_fifo: synchronous FIFO of t_ring_req, pointer + count based.
//   clk, rst   - clock, asynchronous active-high reset
//   push       - write push_data at the next edge (ignored when full)
//   pop        - drop the head at the next edge (ignored when empty)
//   head       - current head entry (valid only when !empty)
//   full/empty - occupancy flags from the count register
//   count      - number of stored entries, 0..DEPTH
module rc_req_fifo
   import lotr_pkg::*;
#(
   parameter int DEPTH = RC_REQ_FIFO_DEPTH,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  t_ring_req     push_data,
   input  logic          pop,
   output t_ring_req     head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   t_ring_req     mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage carries no reset; only the pointers and count define contents.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so pointer wrap is plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/rc_req_out_arb.sv
// rc_req_out_arb: owns the ring request-out slot of one tile.
// Pass-through requests are registered at Q501 and always win the slot at
// Q502; local core requests are queued in rc_req_fifo and fill idle slots.
//   QClk, RstQnnnH        - clock, asynchronous active-high reset
//   CoreID                - tile ID, upper bits of the local requestor
//   Pass*Q500H            - pass-through request in
//   C2F_Req*Q500H         - local core request in
//   C2F_ReqStall          - FIFO full, core holds its request
//   RingReqOut*Q502H      - registered ring slot out
//   StarveAlert           - local queue blocked for >= STARVE_TH cycles
//   OverflowErr           - sticky, push attempted while full
module rc_req_out_arb
   import lotr_pkg::*;
#(
   parameter int FIFO_DEPTH = RC_REQ_FIFO_DEPTH,
   parameter int STARVE_TH  = 16,
   parameter int STARVE_W   = 8
) (
   input  logic        QClk,
   input  logic        RstQnnnH,
   input  logic [7:0]  CoreID,
   input  logic        PassValidQ500H,
   input  logic [9:0]  PassRequestorQ500H,
   input  t_opcode     PassOpcodeQ500H,
   input  logic [31:0] PassAddressQ500H,
   input  logic [31:0] PassDataQ500H,
   input  logic        C2F_ReqValidQ500H,
   input  logic [1:0]  C2F_ReqThreadIDQ500H,
   input  t_opcode     C2F_ReqOpcodeQ500H,
   input  logic [31:0] C2F_ReqAddressQ500H,
   input  logic [31:0] C2F_ReqDataQ500H,
   output logic        C2F_ReqStall,
   output logic        RingReqOutValidQ502H,
   output logic [9:0]  RingReqOutRequestorQ502H,
   output t_opcode     RingReqOutOpcodeQ502H,
   output logic [31:0] RingReqOutAddressQ502H,
   output logic [31:0] RingReqOutDataQ502H,
   output logic        StarveAlert,
   output logic        OverflowErr
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]       DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [STARVE_W-1:0] STARVE_TC = STARVE_W'(STARVE_TH);
   localparam logic [STARVE_W-1:0] CNT_MAX   = '1;

   t_ring_req           pass_req, local_req, q501, out_q, fifo_head;
   logic                push, pop, fifo_full, fifo_empty;
   logic [CW-1:0]       fifo_cnt;
   logic [STARVE_W-1:0] starve_cnt, starve_nxt;

   always_comb begin
      pass_req = '{valid: PassValidQ500H, requestor: PassRequestorQ500H,
                   opcode: PassOpcodeQ500H, address: PassAddressQ500H,
                   data: PassDataQ500H};
      local_req = '{valid: 1'b1, requestor: {CoreID, C2F_ReqThreadIDQ500H},
                    opcode: C2F_ReqOpcodeQ500H, address: C2F_ReqAddressQ500H,
                    data: C2F_ReqDataQ500H};
   end

   // Push eligibility uses the pre-pop count: a full FIFO rejects even when
   // the same cycle pops, keeping stall free of any input-to-output path.
   assign push = C2F_ReqValidQ500H && (fifo_cnt < DEPTH_C);
   assign pop  = !q501.valid && !fifo_empty;

   rc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (QClk),
      .rst       (RstQnnnH),
      .push      (push),
      .push_data (local_req),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_cnt)
   );

   always_comb begin
      starve_nxt = starve_cnt;
      if (fifo_empty || pop)        starve_nxt = '0;
      else if (starve_cnt != CNT_MAX) starve_nxt = starve_cnt + STARVE_W'(1);
   end

   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
         q501        <= '0;
         out_q       <= '0;
         starve_cnt  <= '0;
         StarveAlert <= 1'b0;
         OverflowErr <= 1'b0;
      end else begin
         q501 <= pass_req;
         // Ring has no backpressure: pass-through always takes the slot.
         if (q501.valid)      out_q <= q501;
         else if (!fifo_empty) out_q <= fifo_head;
         else                 out_q.valid <= 1'b0;
         starve_cnt  <= starve_nxt;
         StarveAlert <= (starve_nxt >= STARVE_TC);
         if (C2F_ReqValidQ500H && fifo_full) OverflowErr <= 1'b1;
      end
   end

   assign C2F_ReqStall             = fifo_full;
   assign RingReqOutValidQ502H     = out_q.valid;
   assign RingReqOutRequestorQ502H = out_q.requestor;
   assign RingReqOutOpcodeQ502H    = out_q.opcode;
   assign RingReqOutAddressQ502H   = out_q.address;
   assign RingReqOutDataQ502H      = out_q.data;

endmodule
